muldiv_arbiter: RTL and testbench

MULDIV_ARBITER -- requirements
Module: muldiv_arbiter

---
 rtl/muldiv_arbiter.sv | 136 +++++++++++++
 tb/tb_muldiv_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_arbiter.sv
// Two-requester round-robin front end for a shared multicycle mul/div unit.
// One operation in flight at a time; reserved op 3 is answered with zero locally.
module muldiv_arbiter #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_req0_valid,
    input  logic [1:0]   i_req0_op,
    input  logic [W-1:0] i_req0_a,
    input  logic [W-1:0] i_req0_b,
    input  logic         i_req1_valid,
    input  logic [1:0]   i_req1_op,
    input  logic [W-1:0] i_req1_a,
    input  logic [W-1:0] i_req1_b,
    output logic         o_req0_ready,
    output logic         o_req1_ready,
    output logic         o_rsp0_valid,
    output logic         o_rsp1_valid,
    output logic [W-1:0] o_rsp_result,
    output logic         o_unit_valid,
    output logic [1:0]   o_unit_op,
    output logic [W-1:0] o_unit_a,
    output logic [W-1:0] o_unit_b,
    input  logic         i_unit_done,
    input  logic [W-1:0] i_unit_result,
    output logic         o_busy
);

    // state | meaning
    // IDLE  | waiting for a request, readies may be high
    // ISSUE | start pulse to the unit
    // WAIT  | waiting for unit done
    // RESP  | one-cycle response pulse to the owner
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t         state;
    logic           last_grant;
    logic [1:0]     op_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic           id_q;
    logic           unit_valid_q;
    logic           rsp0_q;
    logic           rsp1_q;
    logic [W-1:0]   result_q;

    logic           grant0;
    logic           grant1;
    logic           accept0;
    logic           accept1;
    logic [1:0]     sel_op;
    logic [W-1:0]   sel_a;
    logic [W-1:0]   sel_b;

    // On a tie the requester that was not granted last wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE && !i_rst) begin
            if (i_req0_valid && (!i_req1_valid || last_grant))
                grant0 = 1'b1;
            else if (i_req1_valid)
                grant1 = 1'b1;
        end
    end

    assign accept0 = i_req0_valid & grant0;
    assign accept1 = i_req1_valid & grant1;
    assign sel_op  = accept1 ? i_req1_op : i_req0_op;
    assign sel_a   = accept1 ? i_req1_a  : i_req0_a;
    assign sel_b   = accept1 ? i_req1_b  : i_req0_b;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= 1'b0;
            unit_valid_q <= 1'b0;
            rsp0_q       <= 1'b0;
            rsp1_q       <= 1'b0;
            result_q     <= '0;
        end else begin
            unit_valid_q <= 1'b0;
            rsp0_q       <= 1'b0;
            rsp1_q       <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept0 || accept1) begin
                        op_q       <= sel_op;
                        a_q        <= sel_a;
                        b_q        <= sel_b;
                        id_q       <= accept1;
                        last_grant <= accept1;
                        if (sel_op == 2'd3) begin
                            // Reserved op never reaches the unit.
                            result_q <= '0;
                            rsp0_q   <= accept0;
                            rsp1_q   <= accept1;
                            state    <= RESP;
                        end else begin
                            unit_valid_q <= 1'b1;
                            state        <= ISSUE;
                        end
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (i_unit_done) begin
                        result_q <= i_unit_result;
                        rsp0_q   <= ~id_q;
                        rsp1_q   <= id_q;
                        state    <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign o_req0_ready = grant0;
    assign o_req1_ready = grant1;
    assign o_rsp0_valid = rsp0_q;
    assign o_rsp1_valid = rsp1_q;
    assign o_rsp_result = result_q;
    assign o_unit_valid = unit_valid_q;
    assign o_unit_op    = op_q;
    assign o_unit_a     = a_q;
    assign o_unit_b     = b_q;
    assign o_busy       = (state != IDLE);

endmodule

// File: tb/tb_muldiv_arbiter.sv
// Directed plus randomized bench for muldiv_arbiter; the bench plays the mul/div unit
// and predicts grants, timing and results from a transaction-level model.
module tb_muldiv_arbiter;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   rv;
    logic [1:0]   rop [2];
    logic [W-1:0] ra  [2];
    logic [W-1:0] rb  [2];
    logic         done;
    logic [W-1:0] ures;

    logic         ready0, ready1, rsp0, rsp1, unit_valid, busy;
    logic [W-1:0] rsp_result, unit_a, unit_b;
    logic [1:0]   unit_op;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int last_g;

    always #5 clk = ~clk;

    muldiv_arbiter #(.W(W)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req0_valid(rv[0]), .i_req0_op(rop[0]), .i_req0_a(ra[0]), .i_req0_b(rb[0]),
        .i_req1_valid(rv[1]), .i_req1_op(rop[1]), .i_req1_a(ra[1]), .i_req1_b(rb[1]),
        .o_req0_ready(ready0), .o_req1_ready(ready1),
        .o_rsp0_valid(rsp0), .o_rsp1_valid(rsp1), .o_rsp_result(rsp_result),
        .o_unit_valid(unit_valid), .o_unit_op(unit_op), .o_unit_a(unit_a), .o_unit_b(unit_b),
        .i_unit_done(done), .i_unit_result(ures), .o_busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] ref_result(input logic [1:0] op, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        case (op)
            2'd0:    return a * b;
            2'd1:    return (b == 0) ? '1 : a / b;
            2'd2:    return (b == 0) ? a : a % b;
            default: return '0;
        endcase
    endfunction

    task automatic do_reset();
        rst  = 1'b1;
        done = 1'b0;
        tick();
        tick();
        rst    = 1'b0;
        last_g = 1;
    endtask

    // Called in IDLE with request inputs already driven; returns in the next IDLE cycle.
    task automatic run_op(input int lat, input bit spur_issue);
        int w;
        logic [1:0]   op;
        logic [W-1:0] a, b, exp;
        #1;
        w = (rv[0] && (!rv[1] || last_g == 1)) ? 0 : 1;
        chk("grant_ready0", ready0, w == 0);
        chk("grant_ready1", ready1, w == 1);
        chk("idle_busy", busy, 1'b0);
        op = rop[w];
        a = ra[w];
        b = rb[w];
        exp = ref_result(op, a, b);
        last_g = w;
        tick();
        chk("post_accept_ready0", ready0, 1'b0);
        chk("post_accept_ready1", ready1, 1'b0);
        chk("post_accept_busy", busy, 1'b1);
        if (op == 2'd3) begin
            chk("rsv_unit_valid", unit_valid, 1'b0);
            chk("rsv_rsp0", rsp0, w == 0);
            chk("rsv_rsp1", rsp1, w == 1);
            chk("rsv_result", rsp_result, '0);
        end else begin
            chk("issue_unit_valid", unit_valid, 1'b1);
            chk("issue_unit_op", unit_op, op);
            chk("issue_unit_a", unit_a, a);
            chk("issue_unit_b", unit_b, b);
            chk("issue_rsp", {rsp1, rsp0}, 2'b00);
            if (spur_issue) begin
                done = 1'b1;
                ures = 32'hdead_beef;
            end
            for (int i = 0; i < lat; i++) begin
                tick();
                done = 1'b0;
                chk("wait_unit_valid", unit_valid, 1'b0);
                chk("wait_rsp", {rsp1, rsp0}, 2'b00);
                chk("wait_readies", {ready1, ready0}, 2'b00);
                chk("wait_busy", busy, 1'b1);
                chk("wait_unit_a_hold", unit_a, a);
            end
            done = 1'b1;
            ures = exp;
            tick();
            done = 1'b0;
            ures = $urandom;
            chk("resp_rsp0", rsp0, w == 0);
            chk("resp_rsp1", rsp1, w == 1);
            chk("resp_result", rsp_result, exp);
            chk("resp_readies", {ready1, ready0}, 2'b00);
        end
        tick();
        chk("after_resp_rsp", {rsp1, rsp0}, 2'b00);
        chk("after_resp_busy", busy, 1'b0);
        chk("result_hold", rsp_result, exp);
    endtask

    task automatic rand_req(input int n, input bit allow_rsv);
        rop[n] = allow_rsv ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 2));
        ra[n]  = $urandom;
        rb[n]  = ($urandom_range(0, 7) == 0) ? '0 : $urandom;
    endtask

    initial begin
        rv = 2'b11;
        rop[0] = 2'd1; rop[1] = 2'd2;
        ra[0] = 5; ra[1] = 6; rb[0] = 7; rb[1] = 8;
        ures = '0;
        do_reset();
        rst = 1'b1;
        #1;
        chk("rst_readies", {ready1, ready0}, 2'b00);
        rst = 1'b0;
        rv = 2'b00;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_unit_valid", unit_valid, 1'b0);
        chk("rst_rsp", {rsp1, rsp0}, 2'b00);
        chk("rst_result", rsp_result, '0);
        chk("rst_unit_op", unit_op, 2'd0);
        chk("rst_unit_a", unit_a, '0);
        chk("rst_unit_b", unit_b, '0);

        // Single multiply 7*6 with the unit finishing 3 cycles after start.
        rv = 2'b01; rop[0] = 2'd0; ra[0] = 7; rb[0] = 6;
        run_op(3, 1'b0);
        chk("mul_result_42", rsp_result, 32'd42);

        // Tie straight out of reset: req0 DIV first, req1 MOD next, then req0 again.
        rv = 2'b00;
        do_reset();
        rv = 2'b11;
        rop[0] = 2'd1; ra[0] = 100; rb[0] = 7;
        rop[1] = 2'd2; ra[1] = 100; rb[1] = 7;
        run_op(2, 1'b0);
        chk("div_result_14", rsp_result, 32'd14);
        run_op(4, 1'b0);
        chk("mod_result_2", rsp_result, 32'd2);
        run_op(1, 1'b0);

        // Reserved op from req1.
        rv = 2'b10; rop[1] = 2'd3;
        run_op(1, 1'b0);

        // Spurious done in IDLE, then in the ISSUE cycle.
        rv = 2'b00; done = 1'b1; ures = 32'h1234_5678;
        tick();
        done = 1'b0;
        chk("spur_idle_busy", busy, 1'b0);
        chk("spur_idle_rsp", {rsp1, rsp0}, 2'b00);
        chk("spur_idle_result", rsp_result, '0);
        rv = 2'b01; rop[0] = 2'd0; ra[0] = 32'h0001_0001; rb[0] = 3;
        run_op(2, 1'b1);

        // Reset during WAIT, stale done afterwards, then a clean request.
        rv = 2'b01; rop[0] = 2'd1; ra[0] = 50; rb[0] = 0;
        #1;
        chk("abandon_ready0", ready0, 1'b1);
        tick();
        rv = 2'b00;
        tick();
        chk("abandon_in_wait_busy", busy, 1'b1);
        rst = 1'b1; rv = 2'b11;
        tick();
        chk("abandon_rst_readies", {ready1, ready0}, 2'b00);
        chk("abandon_rst_busy", busy, 1'b0);
        rst = 1'b0; rv = 2'b00; last_g = 1;
        done = 1'b1; ures = 32'h0bad_0bad;
        tick();
        done = 1'b0;
        chk("stale_done_rsp", {rsp1, rsp0}, 2'b00);
        chk("stale_done_busy", busy, 1'b0);
        chk("stale_done_result", rsp_result, '0);
        rv = 2'b10; rop[1] = 2'd2; ra[1] = 77; rb[1] = 10;
        run_op(2, 1'b0);
        chk("post_abandon_result", rsp_result, 32'd7);

        // Both requesters continuously valid: grants must alternate.
        rv = 2'b00;
        do_reset();
        rv = 2'b11;
        for (int i = 0; i < 8; i++) begin
            rand_req(0, 1'b0);
            rand_req(1, 1'b0);
            run_op($urandom_range(1, 4), 1'b0);
        end

        // Random mix of valids, ops (including reserved) and unit latencies.
        for (int i = 0; i < 40; i++) begin
            rv = 2'($urandom_range(0, 3));
            rand_req(0, 1'b1);
            rand_req(1, 1'b1);
            if (rv == 2'b00) begin
                done = 1'($urandom_range(0, 1));
                #1;
                chk("rand_idle_readies", {ready1, ready0}, 2'b00);
                tick();
                done = 1'b0;
                chk("rand_idle_rsp", {rsp1, rsp0}, 2'b00);
                chk("rand_idle_busy", busy, 1'b0);
            end else begin
                run_op($urandom_range(1, 5), 1'($urandom_range(0, 1)));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
